// File: rtl/of_pkg.sv
// of_pkg: opcode and immediate-mode encodings shared by the operand fetch stage
package of_pkg;
  localparam logic [4:0] OP_ST = 5'b01111;
  localparam logic [4:0] OP_RET = 5'b10100;
  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HIGH = 2'b10;
  localparam logic [1:0] MOD_ZERO = 2'b11;
endpackage

// File: rtl/of_regfile.sv
// of_regfile: NUM_REGS x DATA_W register file, two async read ports, one sync write port
module of_regfile
  import of_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

  // Next register contents: only the addressed entry changes on a write
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/operand_fetch_pipe.sv
// operand_fetch_pipe: decode + register read into a single valid/ready output stage.
// Define OF_WB_BYPASS_EN to forward a same-cycle writeback into captured operands.
module operand_fetch_pipe
  import of_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int RA_IDX = 15,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        opcode,
  output logic              imm_flag,
  output logic [AW-1:0]     rd,
  output logic [DATA_W-1:0] immx,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [DATA_W-1:0] pc_out
);
  logic [4:0]        dec_op;
  logic              dec_imm;
  logic [AW-1:0]     dec_rd, dec_rs1, dec_rs2, ra, rb;
  logic [1:0]        dec_mod;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] dec_immx, dec_bt, rd_a, rd_b, op1_cap, op2_cap;
  logic              cap, hold;

  logic              valid_q, valid_d, imm_flag_q, imm_flag_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [AW-1:0]     rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_W-1:0] immx_q, immx_d, bt_q, bt_d, op1_q, op1_d, op2_q, op2_d, pc_q, pc_d;

  of_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .we(wb_en), .waddr(wb_addr), .wdata(wb_data),
    .raddr_a(ra), .rdata_a(rd_a),
    .raddr_b(rb), .rdata_b(rd_b)
  );

  // Field decode, immediate/branch formation and read-port steering
  always_comb begin
    dec_op   = instr[31:27];
    dec_imm  = instr[26];
    dec_rd   = instr[22 +: AW];
    dec_rs1  = instr[18 +: AW];
    dec_rs2  = instr[14 +: AW];
    dec_mod  = instr[17:16];
    imm16    = instr[15:0];
    dec_immx = !dec_imm              ? '0 :
               dec_mod == MOD_SEXT   ? DATA_W'($signed(imm16)) :
               dec_mod == MOD_ZEXT   ? DATA_W'(imm16) :
               dec_mod == MOD_HIGH   ? DATA_W'({imm16, 16'h0000}) : '0;
    dec_bt   = pc_in + (DATA_W'($signed(instr[26:0])) << 2);
    ra       = dec_op == OP_RET ? AW'(RA_IDX) : dec_rs1;
    rb       = dec_op == OP_ST ? dec_rd : dec_rs2;
`ifdef OF_WB_BYPASS_EN
    op1_cap  = (wb_en && wb_addr == ra) ? wb_data : rd_a;
    op2_cap  = (wb_en && wb_addr == rb) ? wb_data : rd_b;
`else
    op1_cap  = rd_a;
    op2_cap  = rd_b;
`endif
  end

  // Handshake and output-stage next state; held operands track writebacks
  always_comb begin
    in_ready   = !valid_q || out_ready;
    cap        = in_valid && in_ready && !flush;
    hold       = valid_q && !out_ready;
    valid_d    = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : valid_q;
    opcode_d   = cap ? dec_op : opcode_q;
    imm_flag_d = cap ? dec_imm : imm_flag_q;
    rd_d       = cap ? dec_rd : rd_q;
    immx_d     = cap ? dec_immx : immx_q;
    bt_d       = cap ? dec_bt : bt_q;
    pc_d       = cap ? pc_in : pc_q;
    ra_d       = cap ? ra : ra_q;
    rb_d       = cap ? rb : rb_q;
    op1_d      = cap ? op1_cap : (hold && wb_en && wb_addr == ra_q) ? wb_data : op1_q;
    op2_d      = cap ? op2_cap : (hold && wb_en && wb_addr == rb_q) ? wb_data : op2_q;
  end

  // Output stage registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      imm_flag_q <= 1'b0;
      rd_q       <= '0;
      immx_q     <= '0;
      bt_q       <= '0;
      pc_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      imm_flag_q <= imm_flag_d;
      rd_q       <= rd_d;
      immx_q     <= immx_d;
      bt_q       <= bt_d;
      pc_q       <= pc_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
    end
  end

  assign out_valid     = valid_q;
  assign opcode        = opcode_q;
  assign imm_flag      = imm_flag_q;
  assign rd            = rd_q;
  assign immx          = immx_q;
  assign branch_target = bt_q;
  assign pc_out        = pc_q;
  assign op1           = op1_q;
  assign op2           = op2_q;
endmodule

// File: tb/tb_operand_fetch_pipe.sv
// tb_operand_fetch_pipe: directed table vectors plus handshake/writeback/reset sequences
module tb_operand_fetch_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, wb_en = 1'b0;
  logic [31:0] instr = '0, pc_in = '0, wb_data = '0;
  logic [3:0]  wb_addr = '0;
  logic        out_valid, out_ready = 1'b1, imm_flag;
  logic [4:0]  opcode;
  logic [3:0]  rd;
  logic [31:0] immx, branch_target, op1, op2, pc_out;
  int n_chk = 0, n_fail = 0;

  operand_fetch_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .imm_flag(imm_flag), .rd(rd),
    .immx(immx), .branch_target(branch_target), .op1(op1), .op2(op2),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, immx, bt;
    logic [4:0]  op;
    logic        imf;
    logic [3:0]  rd;
  } vec_t;
  vec_t v[6];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic i,
                                      input logic [3:0] r, input logic [3:0] s1,
                                      input logic [17:0] lo);
    return {op, i, r, s1, lo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    v[0] = '{enc(5'h01, 1'b1, 4'd5, 4'd0, 18'h0FFFE), 32'h0,    32'hFFFFFFFE, 32'hF503FFF8, 5'h01, 1'b1, 4'd5};
    v[1] = '{enc(5'h01, 1'b1, 4'd5, 4'd0, 18'h1FFFE), 32'h0,    32'h0000FFFE, 32'hF507FFF8, 5'h01, 1'b1, 4'd5};
    v[2] = '{enc(5'h01, 1'b1, 4'd5, 4'd0, 18'h2FFFE), 32'h0,    32'hFFFE0000, 32'hF50BFFF8, 5'h01, 1'b1, 4'd5};
    v[3] = '{enc(5'h02, 1'b1, 4'hF, 4'hF, 18'h3FFFF), 32'h100,  32'h0,        32'h000000FC, 5'h02, 1'b1, 4'hF};
    v[4] = '{enc(5'h1F, 1'b0, 4'd3, 4'd1, 18'h01234), 32'h1000, 32'h0,        32'h031058D0, 5'h1F, 1'b0, 4'd3};
    v[5] = '{enc(5'h00, 1'b1, 4'd0, 4'd0, 18'h3ABCD), 32'h10,   32'h0,        32'hF00EAF44, 5'h00, 1'b1, 4'd0};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_immx", immx, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; instr = v[k].instr; pc_in = v[k].pc;
      tick();
      chk($sformatf("v%0d_valid", k), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d_opcode", k), {27'b0, opcode}, {27'b0, v[k].op});
      chk($sformatf("v%0d_imm_flag", k), {31'b0, imm_flag}, {31'b0, v[k].imf});
      chk($sformatf("v%0d_rd", k), {28'b0, rd}, {28'b0, v[k].rd});
      chk($sformatf("v%0d_immx", k), immx, v[k].immx);
      chk($sformatf("v%0d_branch", k), branch_target, v[k].bt);
      chk($sformatf("v%0d_pc_out", k), pc_out, v[k].pc);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'h0);

    wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'hDEAD;
    tick();
    wb_addr = 4'd3; wb_data = 32'h55;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; instr = enc(5'b10100, 1'b0, 4'd0, 4'd2, 18'h0);
    tick();
    chk("ret_op1", op1, 32'hDEAD);
    instr = enc(5'b01111, 1'b0, 4'd3, 4'd0, 18'h18000);
    tick();
    chk("store_op2", op2, 32'h55);

    instr = enc(5'h05, 1'b0, 4'd0, 4'd2, 18'h0);
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0;
`ifdef OF_WB_BYPASS_EN
    chk("bypass_op1", op1, 32'h1234);
`else
    chk("bypass_op1", op1, 32'h0);
`endif

    instr = enc(5'h03, 1'b0, 4'd7, 4'd1, 18'h10000);
    tick();
    chk("hold_cap_op2", op2, 32'h0);
    out_ready = 1'b0;
    instr = enc(5'h07, 1'b0, 4'd0, 4'd0, 18'h0);
    #1;
    chk("hold_in_ready0", {31'b0, in_ready}, 32'h0);
    tick();
    chk("hold1_opcode", {27'b0, opcode}, 32'h3);
    chk("hold1_op2", op2, 32'h0);
    chk("hold1_in_ready", {31'b0, in_ready}, 32'h0);
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'hABC;
    tick();
    wb_en = 1'b0;
    chk("hold2_op2", op2, 32'hABC);
    chk("hold2_opcode", {27'b0, opcode}, 32'h3);
    chk("hold2_rd", {28'b0, rd}, 32'h7);
    chk("hold2_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    chk("hold3_op2", op2, 32'hABC);
    chk("hold3_valid", {31'b0, out_valid}, 32'h1);
    chk("hold3_opcode", {27'b0, opcode}, 32'h3);
    chk("hold3_in_ready", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("hold_release", {31'b0, out_valid}, 32'h0);

    in_valid = 1'b1; instr = enc(5'h09, 1'b0, 4'd0, 4'd0, 18'h0);
    tick();
    chk("pre_flush_valid", {31'b0, out_valid}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_opcode_held", {27'b0, opcode}, 32'h9);

    tick();
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_opcode", {27'b0, opcode}, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; instr = enc(5'b10100, 1'b0, 4'd0, 4'd2, 18'h0);
    tick();
    chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
    chk("post_rst_r15", op1, 32'h0);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_fetch_pipe.md
OPERAND_FETCH_PIPE -- requirements
Module: operand_fetch_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and instruction width.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count (power of two).
REQ-003 SHALL have parameter RA_IDX, default 15, return-address register index.
REQ-004 SHALL have ports: clk  input  1  sole clock, rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports: in_valid  input  1; in_ready  output  1; instr  input  DATA_W; pc_in  input  DATA_W.
REQ-006 SHALL have ports: flush  input  1  discard staged instruction; wb_en  input  1; wb_addr  input  log2(NUM_REGS); wb_data  input  DATA_W.
REQ-007 SHALL have ports: out_valid  output  1; out_ready  input  1; opcode  output  5; imm_flag  output  1; rd  output  log2(NUM_REGS).
REQ-008 SHALL have ports: immx, branch_target, op1, op2, pc_out  output  DATA_W each.

Function
REQ-009 SHALL decode opcode=instr[31:27], imm_flag=instr[26], rd=instr[25:22], rs1=instr[21:18], rs2=instr[17:14], mod=instr[17:16], imm16=instr[15:0].
REQ-010 SHALL form immx: mod 00 sign-extend imm16; 01 zero-extend; 10 imm16<<16, low half zero; 11 zero; immx = 0 when imm_flag=0.
REQ-011 SHALL form branch_target = pc_in + (sign-extended instr[26:0] << 2), modulo 2^DATA_W.
REQ-012 SHALL read port A address = RA_IDX when opcode=5'b10100 (ret), else rs1.
REQ-013 SHALL read port B address = rd when opcode=5'b01111 (store), else rs2.
REQ-014 SHALL contain a NUM_REGS x DATA_W register file, written on clk edge when wb_en=1.
REQ-015 SHALL register all decoded outputs in one output stage; latency instr->outputs = 1 cycle.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL capture when in_valid && in_ready: out_valid<=1 next cycle.
REQ-018 SHALL clear out_valid when out_ready=1 and no capture that cycle.
REQ-019 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, while holding, replace held op1/op2 with wb_data when wb_en=1 and wb_addr equals that operand's read address (held operands never stale).
REQ-021 SHALL on flush=1 set out_valid<=0 and block capture that cycle; flush wins over in_valid.
REQ-022 SHALL hold the captured read addresses internally for REQ-020.

Reset
REQ-023 SHALL on rst_n=0, immediately and independent of clk, clear out_valid and all registered outputs to 0 and all register-file entries to 0.
REQ-024 SHALL discard any staged instruction on reset mid-operation; first capture allowed on first clk edge after rst_n rises.

Configuration
REQ-025 SHALL use macro OF_WB_BYPASS_EN.
REQ-026 SHALL, with OF_WB_BYPASS_EN defined, forward wb_data to op1/op2 at capture when wb_en=1 and wb_addr equals the read address (same-cycle write visible).
REQ-027 SHALL, without OF_WB_BYPASS_EN, capture the pre-write register value; REQ-020 still applies.

Structure
REQ-028 SHALL place opcode constants (OP_ST=5'b01111, OP_RET=5'b10100) and mod encodings in shared package of_pkg.
REQ-029 SHALL implement the register file as sub-module of_regfile (2 async read ports, 1 sync write port, async active-low reset).

Verification
REQ-030 SHALL test: imm_flag=1, imm16=16'hFFFE, mod 00/01/10 -> immx 32'hFFFFFFFE / 32'h0000FFFE / 32'hFFFE0000.
REQ-031 SHALL test: pc_in=32'h100, offset 27'h7FFFFFF -> branch_target=32'hFC.
REQ-032 SHALL test: write r15=32'hDEAD, ret instruction -> op1=32'hDEAD next cycle; store with rd=3, r3=32'h55 -> op2=32'h55.
REQ-033 SHALL test: wb_en write r2=32'h1234 same cycle as capture reading r2 -> op1=32'h1234 with OF_WB_BYPASS_EN, old value 0 without.
REQ-034 SHALL test: out_ready=0 for 3 cycles, wb write to held rs2 in cycle 2 -> outputs stable except op2 updated; in_ready=0 throughout.
REQ-035 SHALL test: flush and in_valid together -> out_valid=0 next cycle; rst_n pulse mid-hold -> out_valid=0 and r15 reads 0.
